leb128_fetch: RTL and testbench

LEB128_FETCH -- requirements
Module: leb128_fetch

---
 rtl/leb128_fetch_if.sv | 34 +++
 rtl/leb128_fetch.sv | 184 ++++++++++++++++++
 tb/tb_leb128_fetch.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/leb128_fetch_if.sv
// Request/result and ROM-bus bundle for the LEB128 immediate fetcher.
// fsm_state mirrors the decoder's state register (0 IDLE, 1 FETCH, 2 READ, 3 DONE).
interface leb128_fetch_if #(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4
) ();
  // Handshake: start is accepted only on a rising edge where busy is low;
  // busy stays high from that edge through the DONE cycle, and done pulses
  // for exactly one cycle while value/len/error are valid (no back-pressure).
  logic                         start;
  logic [MEM_DEPTH:0]           pc;
  logic                         is_signed;
  logic                         is64;
  logic                         busy;
  logic                         done;
  logic [63:0]                  value;
  logic [3:0]                   len;
  logic [1:0]                   error;
  logic [MEM_DEPTH:0]           mem_addr;
  logic [MEM_EXTRA-1:0]         mem_extra;
  logic [(2**MEM_EXTRA)*8-1:0]  mem_data;
  logic                         mem_error;
  logic [1:0]                   fsm_state;

  modport slave (
    input  start, pc, is_signed, is64, mem_data, mem_error,
    output busy, done, value, len, error, mem_addr, mem_extra, fsm_state
  );

  modport master (
    output start, pc, is_signed, is64, mem_data, mem_error,
    input  busy, done, value, len, error, mem_addr, mem_extra, fsm_state
  );
endinterface

// File: rtl/leb128_fetch.sv
// LEB128 immediate decoder reading one byte per FETCH/READ pair from a synchronous ROM.
// Define LEB128_STRICT_EN to reject maximum-length final bytes with bits beyond the target width.
module leb128_fetch #(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4
) (
  input logic            clk,
  input logic            reset,
  leb128_fetch_if.slave  bus
);

  localparam int AW = MEM_DEPTH + 1;
  localparam int DW = (2**MEM_EXTRA) * 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;

  logic [AW-1:0] pc_q;
  logic          signed_q;
  logic          is64_q;
  logic [3:0]    count;
  logic [69:0]   acc;
  logic [63:0]   value_q;
  logic [3:0]    len_q;
  logic [1:0]    error_q;

  logic [7:0]    byte_in;
  logic [3:0]    max_len;
  logic [3:0]    len_now;
  logic          last_byte;
  logic [6:0]    shamt;
  logic [6:0]    top_bit;
  logic [69:0]   acc_next;
  logic [69:0]   sext_mask;
  logic [69:0]   ext;
  logic [63:0]   result;
  logic          strict_bad;
  logic          finish;
  logic [1:0]    finish_err;

  // ------------------------------------------------------------------
  // Datapath: fold the current byte into the accumulator and form the
  // result as if this byte were the last one.
  // ------------------------------------------------------------------
  always_comb begin
    byte_in   = bus.mem_data[7:0];
    max_len   = is64_q ? 4'd10 : 4'd5;
    len_now   = count + 4'd1;
    last_byte = (len_now == max_len);
    shamt     = {3'b000, count} * 7'd7;
    top_bit   = ({3'b000, len_now} * 7'd7) - 7'd1;
    acc_next  = acc | ({63'd0, byte_in[6:0]} << shamt);
    sext_mask = {70{1'b1}} << ({3'b000, len_now} * 7'd7);
    ext       = (signed_q && acc_next[top_bit]) ? (acc_next | sext_mask) : acc_next;
    result    = is64_q ? ext[63:0] : {32'd0, ext[31:0]};
  end

`ifdef LEB128_STRICT_EN
  // On a maximum-length byte the bits past the target width must be a
  // plain zero extension (unsigned) or a copy of the sign bit (signed).
  always_comb begin
    strict_bad = 1'b0;
    if (last_byte) begin
      if (is64_q) begin
        if (signed_q) strict_bad = !((byte_in[6:0] == 7'h00) || (byte_in[6:0] == 7'h7F));
        else          strict_bad = |byte_in[6:1];
      end else begin
        if (signed_q) strict_bad = !((byte_in[6:3] == 4'h0) || (byte_in[6:3] == 4'hF));
        else          strict_bad = |byte_in[6:4];
      end
    end
  end
`else
  assign strict_bad = 1'b0;
`endif

  // ------------------------------------------------------------------
  // FSM next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    next_state = state;
    finish     = 1'b0;
    finish_err = 2'd0;
    case (state)
      IDLE: begin
        if (bus.start) next_state = FETCH;
      end
      FETCH: begin
        next_state = READ;
      end
      READ: begin
        if (bus.mem_error) begin
          next_state = DONE;
          finish     = 1'b1;
          finish_err = 2'd1;
        end else if (byte_in[7]) begin
          if (last_byte) begin
            next_state = DONE;
            finish     = 1'b1;
            finish_err = 2'd2;
          end else begin
            next_state = FETCH;
          end
        end else begin
          next_state = DONE;
          finish     = 1'b1;
          finish_err = strict_bad ? 2'd3 : 2'd0;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // ------------------------------------------------------------------
  // Request latch, byte counter and accumulator
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      signed_q <= 1'b0;
      is64_q   <= 1'b0;
      count    <= 4'd0;
      acc      <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        pc_q     <= bus.pc;
        signed_q <= bus.is_signed;
        is64_q   <= bus.is64;
        count    <= 4'd0;
        acc      <= '0;
      end else if (state == READ) begin
        count <= len_now;
        acc   <= acc_next;
      end
    end
  end

  // Results are written once per decode and held until the next one finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= 64'd0;
      len_q   <= 4'd0;
      error_q <= 2'd0;
    end else if (finish) begin
      value_q <= (finish_err == 2'd0) ? result : 64'd0;
      len_q   <= len_now;
      error_q <= finish_err;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // The address is valid in FETCH (ROM samples it) and held through READ.
  assign bus.mem_addr  = (state == FETCH || state == READ) ? (pc_q + AW'(count)) : '0;
  assign bus.mem_extra = '0;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.value     = value_q;
  assign bus.len       = len_q;
  assign bus.error     = error_q;
  assign bus.fsm_state = state;

  logic unused_bits;
  assign unused_bits = ^{bus.mem_data[DW-1:8], ext[69:64]};

endmodule

// File: tb/tb_leb128_fetch.sv
// Directed bench for leb128_fetch: ROM model, per-scenario tasks with inline checks.
// Expectations follow LEB128_STRICT_EN when it is defined for the build.
module tb_leb128_fetch;

  localparam int MEM_DEPTH = 4;
  localparam int MEM_EXTRA = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [7:0] rom [0:31];
  logic       fault_en;
  logic [4:0] fault_addr;
  logic [4:0] got_addr[$];

  leb128_fetch_if #(.MEM_DEPTH(MEM_DEPTH), .MEM_EXTRA(MEM_EXTRA)) bus ();

  leb128_fetch #(.MEM_DEPTH(MEM_DEPTH), .MEM_EXTRA(MEM_EXTRA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous ROM with a planted fault address
  always @(posedge clk) begin
    bus.mem_data  <= {{15{8'hA5}}, rom[bus.mem_addr]};
    bus.mem_error <= fault_en && (bus.mem_addr == fault_addr);
  end

  // driver: one decode, counting edges from the start-sampling edge
  task automatic run_decode(input logic [4:0] p, input logic s, input logic w,
                            output int edges, output logic [63:0] v,
                            output logic [3:0] l, output logic [1:0] e);
    edges = 0;
    got_addr.delete();
    @(negedge clk);
    bus.pc = p; bus.is_signed = s; bus.is64 = w; bus.start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.fsm_state == 2'd2) got_addr.push_back(bus.mem_addr);
      if (bus.done) begin
        edges = c;
        break;
      end
    end
    v = bus.value; l = bus.len; e = bus.error;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.pc = '0; bus.is_signed = 1'b0; bus.is64 = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (bus.busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    if (bus.done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    if (bus.value !== 64'd0)    begin failures++; $display("FAIL reset_value got=%h exp=0", bus.value); end
    if (bus.len !== 4'd0)       begin failures++; $display("FAIL reset_len got=%0d exp=0", bus.len); end
    if (bus.error !== 2'd0)     begin failures++; $display("FAIL reset_error got=%0d exp=0", bus.error); end
    if (bus.mem_addr !== 5'd0)  begin failures++; $display("FAIL reset_mem_addr got=%0d exp=0", bus.mem_addr); end
    if (bus.mem_extra !== 4'd0) begin failures++; $display("FAIL reset_mem_extra got=%0d exp=0", bus.mem_extra); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte;
    int ed; logic [63:0] v; logic [3:0] l; logic [1:0] e;
    run_decode(5'd0, 1'b0, 1'b0, ed, v, l, e);
    checks += 4;
    if (ed !== 3)         begin failures++; $display("FAIL single_latency got=%0d exp=3", ed); end
    if (v !== 64'd42)     begin failures++; $display("FAIL single_value got=%h exp=2a", v); end
    if (l !== 4'd1)       begin failures++; $display("FAIL single_len got=%0d exp=1", l); end
    if (e !== 2'd0)       begin failures++; $display("FAIL single_error got=%0d exp=0", e); end
  endtask

  task automatic test_multi_byte;
    int ed; logic [63:0] v; logic [3:0] l; logic [1:0] e;
    run_decode(5'd2, 1'b0, 1'b0, ed, v, l, e);
    checks += 5;
    if (ed !== 7)           begin failures++; $display("FAIL multi_latency got=%0d exp=7", ed); end
    if (v !== 64'd624485)   begin failures++; $display("FAIL multi_value got=%0d exp=624485", v); end
    if (l !== 4'd3)         begin failures++; $display("FAIL multi_len got=%0d exp=3", l); end
    if (e !== 2'd0)         begin failures++; $display("FAIL multi_error got=%0d exp=0", e); end
    if (got_addr.size() != 3) begin failures++; $display("FAIL multi_addr_count got=%0d exp=3", got_addr.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_addr[i] !== 5'(2 + i)) begin
          failures++; $display("FAIL multi_addr%0d got=%0d exp=%0d", i, got_addr[i], 2 + i);
        end
      end
    end
  endtask

  task automatic test_signed;
    int ed; logic [63:0] v; logic [3:0] l; logic [1:0] e;
    run_decode(5'd6, 1'b1, 1'b0, ed, v, l, e);
    checks += 2;
    if (v !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL signed32_value got=%h exp=00000000ffffffff", v); end
    if (e !== 2'd0) begin failures++; $display("FAIL signed32_error got=%0d exp=0", e); end
    run_decode(5'd6, 1'b1, 1'b1, ed, v, l, e);
    checks += 2;
    if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL signed64_value got=%h exp=ffffffffffffffff", v); end
    if (l !== 4'd1) begin failures++; $display("FAIL signed64_len got=%0d exp=1", l); end
  endtask

  task automatic test_overlong;
    int ed; logic [63:0] v; logic [3:0] l; logic [1:0] e;
    run_decode(5'd8, 1'b0, 1'b0, ed, v, l, e);
    checks += 4;
    if (ed !== 11)    begin failures++; $display("FAIL overlong_latency got=%0d exp=11", ed); end
    if (e !== 2'd2)   begin failures++; $display("FAIL overlong_error got=%0d exp=2", e); end
    if (l !== 4'd5)   begin failures++; $display("FAIL overlong_len got=%0d exp=5", l); end
    if (v !== 64'd0)  begin failures++; $display("FAIL overlong_value got=%h exp=0", v); end
  endtask

  task automatic test_max_len;
    int ed; logic [63:0] v; logic [3:0] l; logic [1:0] e;
    run_decode(5'd14, 1'b0, 1'b0, ed, v, l, e);
    checks += 3;
    if (l !== 4'd5) begin failures++; $display("FAIL max32_len got=%0d exp=5", l); end
`ifdef LEB128_STRICT_EN
    if (e !== 2'd3)  begin failures++; $display("FAIL max32_error got=%0d exp=3", e); end
    if (v !== 64'd0) begin failures++; $display("FAIL max32_value got=%h exp=0", v); end
`else
    if (e !== 2'd0)  begin failures++; $display("FAIL max32_error got=%0d exp=0", e); end
    if (v !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL max32_value got=%h exp=ffffffff", v); end
`endif
    run_decode(5'd20, 1'b0, 1'b1, ed, v, l, e);
    checks += 4;
    if (ed !== 21)   begin failures++; $display("FAIL max64_latency got=%0d exp=21", ed); end
    if (l !== 4'd10) begin failures++; $display("FAIL max64_len got=%0d exp=10", l); end
    if (e !== 2'd0)  begin failures++; $display("FAIL max64_error got=%0d exp=0", e); end
    if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL max64_value got=%h exp=ffffffffffffffff", v); end
  endtask

  task automatic test_wrap;
    int ed; logic [63:0] v; logic [3:0] l; logic [1:0] e;
    run_decode(5'd31, 1'b0, 1'b0, ed, v, l, e);
    checks += 3;
    if (v !== 64'd5377) begin failures++; $display("FAIL wrap_value got=%0d exp=5377", v); end
    if (l !== 4'd2)     begin failures++; $display("FAIL wrap_len got=%0d exp=2", l); end
    if (got_addr.size() != 2 || got_addr[0] !== 5'd31 || got_addr[1] !== 5'd0) begin
      failures++; $display("FAIL wrap_addr got_count=%0d exp=2 (31,0)", got_addr.size());
    end
  endtask

  task automatic test_fault;
    int ed; logic [63:0] v; logic [3:0] l; logic [1:0] e;
    fault_addr = 5'd3; fault_en = 1'b1;
    run_decode(5'd2, 1'b0, 1'b0, ed, v, l, e);
    fault_en = 1'b0;
    checks += 3;
    if (e !== 2'd1)  begin failures++; $display("FAIL fault_error got=%0d exp=1", e); end
    if (l !== 4'd2)  begin failures++; $display("FAIL fault_len got=%0d exp=2", l); end
    if (v !== 64'd0) begin failures++; $display("FAIL fault_value got=%h exp=0", v); end
  endtask

  task automatic test_busy_start;
    int ed; logic [63:0] v;
    ed = 0;
    @(negedge clk);
    bus.pc = 5'd2; bus.is_signed = 1'b0; bus.is64 = 1'b0; bus.start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = (c == 3);
      bus.pc    = (c == 3) ? 5'd0 : 5'd2;
      if (bus.done) begin ed = c; break; end
    end
    bus.start = 1'b0;
    v = bus.value;
    checks += 2;
    if (ed !== 7)         begin failures++; $display("FAIL busy_start_latency got=%0d exp=7", ed); end
    if (v !== 64'd624485) begin failures++; $display("FAIL busy_start_value got=%0d exp=624485", v); end
  endtask

  task automatic test_back_to_back;
    int ed;
    ed = 0;
    @(negedge clk);
    bus.pc = 5'd0; bus.is_signed = 1'b0; bus.is64 = 1'b0; bus.start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done) begin ed = c; break; end
    end
    @(negedge clk);
    checks += 3;
    if (ed !== 3)         begin failures++; $display("FAIL b2b_latency got=%0d exp=3", ed); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_after_done got=%0b exp=0", bus.busy); end
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_restart got=%0b exp=1", bus.busy); end
    for (int c = 0; c < 40 && bus.busy; c++) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int ed; int done_seen; logic [63:0] v; logic [3:0] l; logic [1:0] e;
    done_seen = 0;
    @(negedge clk);
    bus.pc = 5'd2; bus.is_signed = 1'b0; bus.is64 = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.fsm_state !== 2'd2) begin failures++; $display("FAIL mid_state got=%0d exp=2", bus.fsm_state); end
    reset = 1'b0;
    #1;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", bus.busy); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    if (done_seen !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", done_seen); end
    run_decode(5'd0, 1'b0, 1'b0, ed, v, l, e);
    checks += 2;
    if (v !== 64'd42) begin failures++; $display("FAIL mid_recover_value got=%0d exp=42", v); end
    if (ed !== 3)     begin failures++; $display("FAIL mid_recover_latency got=%0d exp=3", ed); end
  endtask

  initial begin
    checks = 0; failures = 0;
    fault_en = 1'b0; fault_addr = 5'd0;
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0] = 8'h2A;
    rom[2] = 8'hE5; rom[3] = 8'h8E; rom[4] = 8'h26;
    rom[6] = 8'h7F;
    for (int i = 8; i < 13; i++) rom[i] = 8'h80;
    rom[14] = 8'hFF; rom[15] = 8'hFF; rom[16] = 8'hFF; rom[17] = 8'hFF; rom[18] = 8'h1F;
    for (int i = 20; i < 29; i++) rom[i] = 8'hFF;
    rom[29] = 8'h01;
    rom[31] = 8'h81;

    test_reset;
    test_single_byte;
    test_multi_byte;
    test_signed;
    test_overlong;
    test_max_len;
    test_wrap;
    test_fault;
    test_busy_start;
    test_back_to_back;
    test_reset_mid;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
